// File: rtl/seg7_pkg.sv
// Shared constants, types and the BCD helper for the seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit codes above 9 that the decoder understands
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Restoring compare-subtract split of a 0..63 value into tens/ones.
  function automatic bcd_t bcd_split(input logic [5:0] v);
    logic [5:0] rem;
    bcd_t       res;
    rem      = v;
    res.tens = 3'd0;
    if (rem >= 6'd40) begin
      rem         = rem - 6'd40;
      res.tens[2] = 1'b1;
    end
    if (rem >= 6'd20) begin
      rem         = rem - 6'd20;
      res.tens[1] = 1'b1;
    end
    if (rem >= 6'd10) begin
      rem         = rem - 6'd10;
      res.tens[0] = 1'b1;
    end
    res.ones = rem[3:0];
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to seven-segment pattern decoder.
// Codes 0..9 are digits, 10 is a dash, anything else is blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:      o_seg = SEG_0;
      4'd1:      o_seg = SEG_1;
      4'd2:      o_seg = SEG_2;
      4'd3:      o_seg = SEG_3;
      4'd4:      o_seg = SEG_4;
      4'd5:      o_seg = SEG_5;
      4'd6:      o_seg = SEG_6;
      4'd7:      o_seg = SEG_7;
      4'd8:      o_seg = SEG_8;
      4'd9:      o_seg = SEG_9;
      CODE_DASH: o_seg = SEG_DASH;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Snapshots hr/min, splits them into four BCD digit codes and time-multiplexes
// them onto a common-anode 4-digit display with anti-ghost blanking and blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 8,
  parameter int BLINK_DIV = 250,
  parameter int LZ_BLANK  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hr,
  input  logic [5:0] min,
  input  logic       load,
  input  logic       blink_en,
  output logic [6:0] seg_out,
  output logic [3:0] anode_out,
  output logic [1:0] digit_idx
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    HR_TENS_RST = (LZ_BLANK != 0) ? CODE_BLANK : 4'd0;

  logic [4:0]       r_shadow_hr;
  logic [5:0]       r_shadow_min;
  logic [3:0][3:0]  r_dig;
  logic [CW-1:0]    r_cnt;
  digit_idx_t       r_idx;
  logic [BW-1:0]    r_blink_cnt;
  logic             r_blink_ph;
  logic [6:0]       r_seg;
  logic [3:0]       r_anode;

  bcd_t             w_hr_bcd;
  bcd_t             w_min_bcd;
  logic [3:0][3:0]  w_dig_next;
  logic             w_tick;
  logic [CW-1:0]    w_cnt_next;
  digit_idx_t       w_idx_next;
  logic [BW-1:0]    w_blink_cnt_next;
  logic             w_blink_ph_next;
  logic             w_blank_win;
  logic [6:0]       w_pat;
  logic [3:0]       w_anode_next;

  assign w_hr_bcd  = bcd_split({1'b0, r_shadow_hr});
  assign w_min_bcd = bcd_split(r_shadow_min);

  // Range check is per pair; an out-of-range hour also overrides leading-zero blanking.
  always_comb begin
    w_dig_next[0] = w_min_bcd.ones;
    w_dig_next[1] = {1'b0, w_min_bcd.tens};
    w_dig_next[2] = w_hr_bcd.ones;
    w_dig_next[3] = {1'b0, w_hr_bcd.tens};
    if (r_shadow_min > MIN_MAX) begin
      w_dig_next[0] = CODE_DASH;
      w_dig_next[1] = CODE_DASH;
    end
    if (r_shadow_hr > HR_MAX) begin
      w_dig_next[2] = CODE_DASH;
      w_dig_next[3] = CODE_DASH;
    end else if ((LZ_BLANK != 0) && (r_shadow_hr < 5'd10)) begin
      w_dig_next[3] = CODE_BLANK;
    end
  end

  assign w_tick     = (r_cnt == CNT_LAST);
  assign w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;
  assign w_idx_next = w_tick ? r_idx + 2'd1 : r_idx;

  always_comb begin
    w_blink_cnt_next = r_blink_cnt;
    w_blink_ph_next  = r_blink_ph;
    if (!blink_en) begin
      w_blink_cnt_next = '0;
      w_blink_ph_next  = 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_next = '0;
        w_blink_ph_next  = ~r_blink_ph;
      end else begin
        w_blink_cnt_next = r_blink_cnt + 1'b1;
      end
    end
  end

  generate
    if (BLANK_CYC > 0) begin : g_blank
      assign w_blank_win = (w_cnt_next < CW'(BLANK_CYC));
    end else begin : g_no_blank
      assign w_blank_win = 1'b0;
    end
  endgenerate

  assign w_anode_next = (w_blank_win || w_blink_ph_next) ? 4'hF : ~(4'b0001 << w_idx_next);

  seg7_decode u_decode (
    .i_code (r_dig[w_idx_next]),
    .o_seg  (w_pat)
  );

  // Segments only change at slot boundaries so a new snapshot never lands mid-slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_hr  <= '0;
      r_shadow_min <= '0;
      r_dig        <= {HR_TENS_RST, 4'd0, 4'd0, 4'd0};
      r_cnt        <= '0;
      r_idx        <= '0;
      r_blink_cnt  <= '0;
      r_blink_ph   <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_anode      <= 4'hF;
    end else begin
      if (load) begin
        r_shadow_hr  <= hr;
        r_shadow_min <= min;
      end
      r_dig       <= w_dig_next;
      r_cnt       <= w_cnt_next;
      r_idx       <= w_idx_next;
      r_blink_cnt <= w_blink_cnt_next;
      r_blink_ph  <= w_blink_ph_next;
      if (w_tick) begin
        r_seg <= w_pat;
      end
      r_anode <= w_anode_next;
    end
  end

  assign seg_out   = r_seg;
  assign anode_out = r_anode;
  assign digit_idx = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a time-based
// reference model (slot/phase derived from the edge count since reset).
module tb_seg7_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int BLINK_DIV = 2;
  localparam int LZ_BLANK  = 1;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [4:0] hr       = '0;
  logic [5:0] min      = '0;
  logic       load     = 1'b0;
  logic       blink_en = 1'b0;
  logic [6:0] seg_out;
  logic [3:0] anode_out;
  logic [1:0] digit_idx;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: k = clock edges since reset release, snapshot history per edge
  int k;
  int cur_h;
  int cur_m;
  int blink_ticks;
  int sh_h [4096];
  int sh_m [4096];
  logic [6:0] pat_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg7_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .BLINK_DIV (BLINK_DIV),
    .LZ_BLANK  (LZ_BLANK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hr        (hr),
    .min       (min),
    .load      (load),
    .blink_en  (blink_en),
    .seg_out   (seg_out),
    .anode_out (anode_out),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [6:0] exp_digit(input int h, input int m, input int idx);
    logic [6:0] p;
    case (idx)
      0:       p = (m > 59) ? 7'h3F : pat_tab[m % 10];
      1:       p = (m > 59) ? 7'h3F : pat_tab[m / 10];
      2:       p = (h > 23) ? 7'h3F : pat_tab[h % 10];
      default: p = (h > 23) ? 7'h3F : ((h < 10) ? 7'h7F : pat_tab[h / 10]);
    endcase
    return p;
  endfunction

  function automatic bit model_blink_off();
    return ((blink_ticks / BLINK_DIV) % 2) == 1;
  endfunction

  task automatic model_reset();
    k           = 0;
    cur_h       = 0;
    cur_m       = 0;
    blink_ticks = 0;
    sh_h[0]     = 0;
    sh_m[0]     = 0;
  endtask

  // One clock edge: update the model with the sampled inputs, then compare.
  task automatic step();
    int         t;
    int         e_idx;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    @(posedge clk);
    k++;
    if (load) begin
      cur_h = int'(hr);
      cur_m = int'(min);
    end
    sh_h[k] = cur_h;
    sh_m[k] = cur_m;
    if (!blink_en) blink_ticks = 0;
    else if (k % SCAN_DIV == 0) blink_ticks++;
    #1;
    e_idx = (k / SCAN_DIV) % 4;
    t     = k - (k % SCAN_DIV);
    // A slot shows the snapshot taken at least two edges before the slot began
    e_seg = (t == 0) ? 7'h7F : exp_digit(sh_h[t-2], sh_m[t-2], e_idx);
    e_an  = ((k % SCAN_DIV) < BLANK_CYC || model_blink_off()) ? 4'hF : ~(4'b0001 << e_idx);
    check_eq("digit_idx", 32'(digit_idx), 32'(e_idx));
    check_eq("anode_out", 32'(anode_out), 32'(e_an));
    check_eq("seg_out",   32'(seg_out),   32'(e_seg));
  endtask

  task automatic do_load(input int h, input int m, input int settle);
    hr   = 5'(h);
    min  = 6'(m);
    load = 1'b1;
    $display("load hr=%0d min=%0d at edge %0d", h, m, k + 1);
    step();
    load = 1'b0;
    repeat (settle) step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_seg",   32'(seg_out),   32'h7F);
    check_eq("rst_anode", 32'(anode_out), 32'hF);
    check_eq("rst_idx",   32'(digit_idx), 32'h0);
    #2;
    reset = 1'b0;
    model_reset();

    // Reset state scan with no snapshot
    repeat (36) step();

    // Directed snapshots including range and leading-zero cases
    do_load(23, 59, 24);
    do_load(7, 5, 24);
    do_load(24, 60, 24);
    do_load(0, 0, 24);
    do_load(12, 34, 24);

    // Blink, then drop it during an off phase so the next edge is a slot boundary
    blink_en = 1'b1;
    $display("blink_en=1 at edge %0d", k + 1);
    for (int i = 0; i < 40; i++) begin
      step();
      if (i > 8 && model_blink_off() && ((k + 1) % SCAN_DIV == 0)) break;
    end
    blink_en = 1'b0;
    $display("blink_en=0 at edge %0d", k + 1);
    repeat (16) step();

    // Randomized snapshots and blink toggling
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        hr   = 5'($urandom_range(0, 31));
        min  = 6'($urandom_range(0, 63));
        load = 1'b1;
        $display("load hr=%0d min=%0d at edge %0d", hr, min, k + 1);
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 24) == 0) blink_en = ~blink_en;
      step();
    end
    load     = 1'b0;
    blink_en = 1'b0;
    repeat (12) step();

    // Asynchronous reset in the middle of the hour-ones slot
    for (int i = 0; i < 20; i++) begin
      if (((k / SCAN_DIV) % 4) == 2 && (k % SCAN_DIV) == 2) break;
      step();
    end
    check_eq("pre_reset_anode", 32'(anode_out), 32'hB);
    #2;
    reset = 1'b1;
    $display("reset asserted mid-slot at edge %0d", k);
    #1;
    check_eq("async_seg",   32'(seg_out),   32'h7F);
    check_eq("async_anode", 32'(anode_out), 32'hF);
    check_eq("async_idx",   32'(digit_idx), 32'h0);
    #2;
    reset = 1'b0;
    model_reset();
    repeat (36) step();
    do_load(9, 41, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
